// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline defines: stage field layouts, bubble encodings and counter limits.
// Also imported by the forward unit so both sides agree on the stage formats.
package hazard_tracker_pkg;

   localparam int REG_W   = 3;
   localparam int INSTR_W = 16;
   localparam int CNT_W   = 16;
   localparam int RS_LSB  = 8;
   localparam int RT_LSB  = 5;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             memread;
      logic [REG_W-1:0] dst;
   } exstage_t;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic [REG_W-1:0] dst;
   } wbstage_t;

   localparam int EX_W = $bits(exstage_t);
   localparam int WB_W = $bits(wbstage_t);

   // A bubble is the all-zero encoding in every stage.
   localparam exstage_t EX_BUBBLE = '0;
   localparam wbstage_t WB_BUBBLE = '0;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hzd_stage_reg.sv
// Generic pipeline stage flop: async active-low reset to all-zero (bubble),
// loads only when enabled.
module hzd_stage_reg #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/hazard_tracker.sv
// Shadows the ID/EX, EX/MEM and MEM/WB control fields, detects load-use hazards
// and counts the single-cycle bubbles they insert.
module hazard_tracker
   import hazard_tracker_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] ID_Instr,
   input  logic               ID_Valid,
   input  logic               ID_RegWriteEN,
   input  logic               ID_MemRead,
   input  logic               ID_ValidRs,
   input  logic               ID_ValidRt,
   input  logic [REG_W-1:0]   ID_DstRegNum,
   input  logic               Freeze,
   input  logic               Flush,
   input  logic               StallCntClr,
   output logic               LoadUseStall,
   output logic               EXMEM_RegWriteEN,
   output logic               MEMWB_RegWriteEN,
   output logic [REG_W-1:0]   EXMEM_DstRegNum,
   output logic [REG_W-1:0]   MEMWB_DstRegNum,
   output logic [CNT_W-1:0]   StallCnt
);

   exstage_t         idex_d, idex_q;
   exstage_t         exmem_d, exmem_q;
   wbstage_t         memwb_d, memwb_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [REG_W-1:0] id_rs, id_rt;
   logic             stage_en;
   logic             load_in_ex;
   logic             hazard_rs, hazard_rt;
   logic             unused_bits;

   assign id_rs    = ID_Instr[RS_LSB +: REG_W];
   assign id_rt    = ID_Instr[RT_LSB +: REG_W];
   assign stage_en = ~Freeze;

   // Only a load in EX can stall; by the time it reaches MEM the result is forwardable.
   assign load_in_ex   = idex_q.valid & idex_q.memread & idex_q.regwrite;
   assign hazard_rs    = ID_ValidRs & (idex_q.dst == id_rs);
   assign hazard_rt    = ID_ValidRt & (idex_q.dst == id_rt);
   assign LoadUseStall = load_in_ex & ID_Valid & (hazard_rs | hazard_rt) & ~Freeze & ~Flush;

   always_comb begin
      idex_d = EX_BUBBLE;
      if (ID_Valid && !Flush && !LoadUseStall) begin
         idex_d.valid    = 1'b1;
         idex_d.regwrite = ID_RegWriteEN;
         idex_d.memread  = ID_MemRead;
         idex_d.dst      = ID_DstRegNum;
      end
   end

   assign exmem_d = idex_q;

   always_comb begin
      memwb_d          = WB_BUBBLE;
      memwb_d.valid    = exmem_q.valid;
      memwb_d.regwrite = exmem_q.regwrite;
      memwb_d.dst      = exmem_q.dst;
   end

   hzd_stage_reg #(.DATA_W(EX_W)) u_idex (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (stage_en),
      .d_i   (idex_d),
      .q_o   (idex_q)
   );

   hzd_stage_reg #(.DATA_W(EX_W)) u_exmem (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (stage_en),
      .d_i   (exmem_d),
      .q_o   (exmem_q)
   );

   hzd_stage_reg #(.DATA_W(WB_W)) u_memwb (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (stage_en),
      .d_i   (memwb_d),
      .q_o   (memwb_q)
   );

   // Freeze beats clear, clear beats increment; the count sticks at all-ones.
   assign stall_cnt_d = Freeze ? stall_cnt_q :
                        StallCntClr ? '0 :
                        (LoadUseStall && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 :
                        stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign EXMEM_RegWriteEN = exmem_q.valid & exmem_q.regwrite;
   assign MEMWB_RegWriteEN = memwb_q.valid & memwb_q.regwrite;
   assign EXMEM_DstRegNum  = exmem_q.dst;
   assign MEMWB_DstRegNum  = memwb_q.dst;
   assign StallCnt         = stall_cnt_q;

   assign unused_bits = ^{ID_Instr[15:11], ID_Instr[4:0], exmem_q.memread};

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios plus random traffic against a
// queue-based model of the three shadow stages.
module tb_hazard_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ID_Instr;
   logic        ID_Valid, ID_RegWriteEN, ID_MemRead, ID_ValidRs, ID_ValidRt;
   logic [2:0]  ID_DstRegNum;
   logic        Freeze, Flush, StallCntClr;
   logic        LoadUseStall, EXMEM_RegWriteEN, MEMWB_RegWriteEN;
   logic [2:0]  EXMEM_DstRegNum, MEMWB_DstRegNum;
   logic [15:0] StallCnt;

   hazard_tracker dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ID_Instr         (ID_Instr),
      .ID_Valid         (ID_Valid),
      .ID_RegWriteEN    (ID_RegWriteEN),
      .ID_MemRead       (ID_MemRead),
      .ID_ValidRs       (ID_ValidRs),
      .ID_ValidRt       (ID_ValidRt),
      .ID_DstRegNum     (ID_DstRegNum),
      .Freeze           (Freeze),
      .Flush            (Flush),
      .StallCntClr      (StallCntClr),
      .LoadUseStall     (LoadUseStall),
      .EXMEM_RegWriteEN (EXMEM_RegWriteEN),
      .MEMWB_RegWriteEN (MEMWB_RegWriteEN),
      .EXMEM_DstRegNum  (EXMEM_DstRegNum),
      .MEMWB_DstRegNum  (MEMWB_DstRegNum),
      .StallCnt         (StallCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit       rw;
      bit       mr;
      bit [2:0] dst;
   } ent_t;

   // pipe[0] = instruction in EX, pipe[1] = in MEM, pipe[2] = in WB
   ent_t pipe[$];
   int   exp_cnt;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ent_t z;
      z = '{v: 1'b0, rw: 1'b0, mr: 1'b0, dst: 3'd0};
      pipe.delete();
      repeat (3) pipe.push_back(z);
      exp_cnt = 0;
   endtask

   task automatic set_id(input bit v, input bit rw, input bit mr, input bit [2:0] d,
                         input bit [2:0] rs, input bit vrs, input bit [2:0] rt, input bit vrt);
      ID_Valid      = v;
      ID_RegWriteEN = rw;
      ID_MemRead    = mr;
      ID_DstRegNum  = d;
      ID_ValidRs    = vrs;
      ID_ValidRt    = vrt;
      ID_Instr      = {5'($urandom), rs, rt, 5'($urandom)};
   endtask

   task automatic idle();
      set_id(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      Freeze      = 1'b0;
      Flush       = 1'b0;
      StallCntClr = 1'b0;
   endtask

   // A decode instruction must wait when it reads the register a load in EX is about to write.
   function automatic bit model_stall();
      ent_t e;
      bit   dep;
      e   = pipe[0];
      dep = (ID_ValidRs && (e.dst == ID_Instr[10:8])) || (ID_ValidRt && (e.dst == ID_Instr[7:5]));
      return !Freeze && !Flush && e.v && e.mr && e.rw && ID_Valid && dep;
   endfunction

   task automatic cycle();
      bit   stall;
      ent_t ne;
      #1;
      stall = model_stall();
      check("LoadUseStall",     32'(LoadUseStall),     32'(stall));
      check("EXMEM_RegWriteEN", 32'(EXMEM_RegWriteEN), 32'(pipe[1].v && pipe[1].rw));
      check("EXMEM_DstRegNum",  32'(EXMEM_DstRegNum),  32'(pipe[1].dst));
      check("MEMWB_RegWriteEN", 32'(MEMWB_RegWriteEN), 32'(pipe[2].v && pipe[2].rw));
      check("MEMWB_DstRegNum",  32'(MEMWB_DstRegNum),  32'(pipe[2].dst));
      check("StallCnt",         32'(StallCnt),         exp_cnt);
      @(posedge clk);
      if (!Freeze) begin
         if (StallCntClr) exp_cnt = 0;
         else if (stall && exp_cnt < 65535) exp_cnt++;
         ne = '{v: 1'b0, rw: 1'b0, mr: 1'b0, dst: 3'd0};
         if (ID_Valid && !Flush && !stall)
            ne = '{v: 1'b1, rw: ID_RegWriteEN, mr: ID_MemRead, dst: ID_DstRegNum};
         pipe.push_front(ne);
         void'(pipe.pop_back());
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      model_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_exmem_we",  32'(EXMEM_RegWriteEN), 32'd0);
      check("rst_exmem_dst", 32'(EXMEM_DstRegNum),  32'd0);
      check("rst_memwb_we",  32'(MEMWB_RegWriteEN), 32'd0);
      check("rst_memwb_dst", 32'(MEMWB_DstRegNum),  32'd0);
      check("rst_lus",       32'(LoadUseStall),     32'd0);
      check("rst_cnt",       32'(StallCnt),         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // load r3, then ADD reading r3 via Rs
      set_id(1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 1, 0, 3'd4, 3'd3, 1, 3'd6, 1);
      #1 check("ldu_stall", 32'(LoadUseStall), 32'd1);
      cycle();
      check("ldu_cnt", 32'(StallCnt), 32'd1);
      #1 check("ldu_once", 32'(LoadUseStall), 32'd0);
      cycle();
      check("ldu_memwb_we",  32'(MEMWB_RegWriteEN), 32'd1);
      check("ldu_memwb_dst", 32'(MEMWB_DstRegNum),  32'd3);
      idle();
      StallCntClr = 1'b1;
      cycle();
      StallCntClr = 1'b0;
      repeat (2) cycle();

      // Rt matches the load but is not a real source operand
      set_id(1, 1, 1, 3'd5, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 1, 0, 3'd1, 3'd2, 1, 3'd5, 0);
      #1 check("rt_invalid_nostall", 32'(LoadUseStall), 32'd0);
      cycle();
      check("rt_invalid_cnt", 32'(StallCnt), 32'd0);
      idle();
      repeat (3) cycle();

      // Flush in the same cycle as the hazard
      set_id(1, 1, 1, 3'd2, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 1, 0, 3'd6, 3'd2, 1, 3'd0, 0);
      Flush = 1'b1;
      #1 check("flush_nostall", 32'(LoadUseStall), 32'd0);
      cycle();
      Flush = 1'b0;
      check("flush_load_we",  32'(EXMEM_RegWriteEN), 32'd1);
      check("flush_load_dst", 32'(EXMEM_DstRegNum),  32'd2);
      idle();
      cycle();
      check("flush_bubble", 32'(EXMEM_RegWriteEN), 32'd0);
      repeat (2) cycle();

      // Freeze held over a pending hazard
      set_id(1, 1, 1, 3'd1, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 0, 0, 3'd0, 3'd0, 0, 3'd1, 1);
      Freeze = 1'b1;
      repeat (3) cycle();
      check("frz_cnt", 32'(StallCnt), 32'd0);
      Freeze = 1'b0;
      #1 check("frz_release_stall", 32'(LoadUseStall), 32'd1);
      cycle();
      check("frz_release_cnt", 32'(StallCnt), 32'd1);
      idle();
      Freeze      = 1'b1;
      StallCntClr = 1'b1;
      cycle();
      check("clr_under_freeze", 32'(StallCnt), 32'd1);
      Freeze = 1'b0;
      cycle();
      StallCntClr = 1'b0;
      check("clr", 32'(StallCnt), 32'd0);
      repeat (2) cycle();

      // saturation: preload the counter one below the top
      force dut.stall_cnt_d = 16'hFFFE;
      cycle();
      release dut.stall_cnt_d;
      exp_cnt = 65534;
      check("sat_preset", 32'(StallCnt), 32'h0000FFFE);
      set_id(1, 1, 1, 3'd7, 3'd7, 1, 3'd0, 0);
      repeat (2) cycle();
      check("sat_top", 32'(StallCnt), 32'h0000FFFF);
      repeat (2) cycle();
      check("sat_hold", 32'(StallCnt), 32'h0000FFFF);
      cycle();
      StallCntClr = 1'b1;
      #1 check("sat_clr_vs_stall", 32'(LoadUseStall), 32'd1);
      cycle();
      StallCntClr = 1'b0;
      check("sat_clr", 32'(StallCnt), 32'd0);
      idle();
      repeat (3) cycle();

      // async reset in the middle of a stall
      set_id(1, 1, 0, 3'd6, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 1, 1, 3'd4, 3'd0, 0, 3'd0, 0);
      cycle();
      set_id(1, 1, 0, 3'd5, 3'd4, 1, 3'd4, 1);
      #1 check("mid_rst_pre_stall", 32'(LoadUseStall), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_lus",      32'(LoadUseStall),     32'd0);
      check("mid_rst_exmem_we", 32'(EXMEM_RegWriteEN), 32'd0);
      check("mid_rst_memwb_we", 32'(MEMWB_RegWriteEN), 32'd0);
      check("mid_rst_cnt",      32'(StallCnt),         32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      idle();
      cycle();
      check("post_rst_flow_we",  32'(EXMEM_RegWriteEN), 32'd1);
      check("post_rst_flow_dst", 32'(EXMEM_DstRegNum),  32'd5);
      repeat (2) cycle();

      // random traffic on a narrow register range so hazards are frequent
      for (int i = 0; i < 3000; i++) begin
         set_id(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 4) < 2),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
                3'($urandom_range(0, 3)), 1'($urandom));
         Freeze      = ($urandom_range(0, 9) == 0);
         Flush       = ($urandom_range(0, 9) == 0);
         StallCntClr = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
